hack_cpu: RTL and testbench
===========================

Name: hack_cpu

Overview:
- Nand2tetris Hack CPU: executes one 16-bit Hack instruction per clock from combinational instruction ROM; talks to a data memory/IO map through split read and write address ports.
- Sits in the Hack SoC top between instruction ROM (indexed by pc), data RAM/memory-mapped IO (combinational read via addressMR, clocked write via addressMW/writeM/outM).
- Holds A, D and PC registers; contains the Hack ALU.

Parameters:
- WIDTH, 16, data/address/instruction width (only 16 supported).

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rstn  in  1  reset, synchronous, active-low
- inM  in  16  M value = memory[addressMR], combinational from memory
- instruction  in  16  instruction at ROM[pc], combinational
- outM  out  16  data to write to memory
- writeM  out  1  memory write strobe, sampled by memory at rising edge
- addressMR  out  16  data-memory read address
- addressMW  out  16  data-memory write address
- pc  out  16  address of current instruction

Behaviour:
- Reset (rstn=0 at rising edge): A=0, D=0, pc=0; writeM forced 0 while rstn=0; no ALU result committed. First instruction after release is ROM[0].
- A-instruction (bit15=0): A <= {1'b0, instruction[14:0]}; D unchanged; writeM=0; pc <= pc+1.
- C-instruction (bit15=1; bits14:13 ignored): a=bit12, c=bits11:6 (zx,nx,zy,ny,f,no), d=bits5:3 (A,D,M), j=bits2:0 (lt,eq,gt).
- ALU inputs: x=D, y = a ? inM : A. zx/zy zero, nx/ny invert, f=1 add (mod 2^16, carry dropped), f=0 bitwise AND, no inverts result. zr = (out==0), ng = out[15].
- Destinations: dA -> A <= out; dD -> D <= out; dM -> writeM=1, outM=out, write address = A value before this instruction's update (AM=... writes to old A).
- Jump taken if (lt&ng)|(eq&zr)|(gt&!ng&!zr); then pc <= old A (pre-update), else pc <= pc+1. j=111 unconditional.
- pc wraps 0xFFFF -> 0x0000.
- addressMR = A (current register value), combinational.
- Default write port (macro absent): combinational; addressMW = A, outM = ALU out, writeM = C-instr & dM & rstn. Memory commits at the same edge the CPU updates A/D/pc.
- outM when writeM=0: ALU out (don't-care for memory, but deterministic).

Optional Feature:
- HACK_CPU_WBREG_EN: registered write port for timing. outM, addressMW, writeM become registers loaded at the edge ending the instruction; memory commits one cycle later. Reset clears writeM reg to 0, outM/addressMW to 0. Forwarding: if registered writeM=1 and addressMW==addressMR, ALU y-input (a=1) uses registered outM instead of inM. Back-to-back M writes legal, one per cycle.
- Without macro: combinational write port as above, no forwarding logic.

Decomposition:
- Package hack_cpu_pkg: instruction field bit positions (C flag 15, a 12, comp 11:6, dest 5:3, jump 2:0), dest bit indices, jump codes (JGT=001, JEQ=010, JMP=111 etc).
- One sub-module: hack_alu (x, y, zx, nx, zy, ny, f, no -> out, zr, ng), purely combinational.

Test Plan:
- Reset: rstn=0 for 3 cycles -> pc=0, writeM=0; release -> pc steps 0,1,2,3 on NOP-like A-instrs.
- @5 (0x0005) then D=A (0xEC10) -> A=5, addressMR=5, D=5; pc=2.
- With A=100, D=5: M=D+1 (0xE7C8) -> writeM=1, outM=6, addressMW=100; D/A unchanged. With HACK_CPU_WBREG_EN, strobe appears one cycle later, and following D=M (0xFC10) loads D=6 via forwarding.
- A=7, inM=0x1234: D=M (0xFC10) -> D=0x1234, writeM=0; AM=M+1 (0xFDE8) -> write 0x1235 to address 7 (old A), A=0x1235.
- A=10, D=0: D;JEQ (0xE302) -> pc=10; D=1 then D;JEQ -> pc+1; D=0xFFFF then D;JLT (0xE304) -> pc=A.
- pc=0xFFFF with non-jump -> pc=0x0000; 0;JMP (0xEA87) with A=0x0003 -> pc=3.

Source files
------------

// File: rtl/hack_cpu_pkg.sv
// Hack CPU shared definitions: instruction field positions, destination bits, jump codes.
package hack_cpu_pkg;

  localparam int HACK_WIDTH = 16;

  // Instruction field positions
  localparam int C_BIT   = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  // Bit indices inside the 3-bit dest field
  localparam int DEST_A = 2;
  localparam int DEST_D = 1;
  localparam int DEST_M = 0;

  typedef enum logic [2:0] {
    JNULL = 3'b000,
    JGT   = 3'b001,
    JEQ   = 3'b010,
    JGE   = 3'b011,
    JLT   = 3'b100,
    JNE   = 3'b101,
    JLE   = 3'b110,
    JMP   = 3'b111
  } jump_t;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } comp_t;

  // Jump bits are lt/eq/gt masks tested against the ALU sign and zero flags.
  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    jump_taken = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: combinational zero/negate of each input, add or AND, optional output negate.
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] x_z;
  logic [WIDTH-1:0] x_n;
  logic [WIDTH-1:0] y_z;
  logic [WIDTH-1:0] y_n;
  logic [WIDTH-1:0] res;

  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
  end

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU: one instruction per clock, A/D/PC registers, split memory read/write addresses.
// Define HACK_CPU_WBREG_EN for a registered write port (one-cycle-late commit, with M forwarding).
module hack_cpu
  import hack_cpu_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] inM,
  input  logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] outM,
  output logic             writeM,
  output logic [WIDTH-1:0] addressMR,
  output logic [WIDTH-1:0] addressMW,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] pc_reg;

  logic             is_c;
  comp_t            comp;
  logic [2:0]       dest;
  logic [2:0]       jump;
  logic             wr_m;
  logic             take;

  logic [WIDTH-1:0] m_val;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] alu_out;
  logic             zr;
  logic             ng;

  assign is_c = instruction[C_BIT];
  assign comp = comp_t'(instruction[COMP_HI:COMP_LO]);
  assign dest = instruction[DEST_HI:DEST_LO];
  assign jump = instruction[JUMP_HI:JUMP_LO];
  assign wr_m = is_c & dest[DEST_M];
  assign take = is_c & jump_taken(jump, zr, ng);

  assign addressMR = a_reg;
  assign pc        = pc_reg;
  assign y_in      = instruction[A_BIT] ? m_val : a_reg;

  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x   (d_reg),
    .y   (y_in),
    .zx  (comp.zx),
    .nx  (comp.nx),
    .zy  (comp.zy),
    .ny  (comp.ny),
    .f   (comp.f),
    .no  (comp.no),
    .out (alu_out),
    .zr  (zr),
    .ng  (ng)
  );

  // Jump target and M write address both use A as it was before this instruction.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_reg  <= '0;
      d_reg  <= '0;
      pc_reg <= '0;
    end else begin
      if (!is_c) begin
        a_reg <= {1'b0, instruction[WIDTH-2:0]};
      end else if (dest[DEST_A]) begin
        a_reg <= alu_out;
      end
      if (is_c && dest[DEST_D]) begin
        d_reg <= alu_out;
      end
      pc_reg <= take ? a_reg : pc_reg + WIDTH'(1);
    end
  end

`ifdef HACK_CPU_WBREG_EN
  logic [WIDTH-1:0] wb_out;
  logic [WIDTH-1:0] wb_addr;
  logic             wb_we;
  logic             fwd;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_out  <= '0;
      wb_addr <= '0;
      wb_we   <= 1'b0;
    end else begin
      wb_out  <= alu_out;
      wb_addr <= a_reg;
      wb_we   <= wr_m;
    end
  end

  // Memory has not yet absorbed the pending write, so read it from the write register.
  assign fwd       = wb_we && (wb_addr == a_reg);
  assign m_val     = fwd ? wb_out : inM;
  assign outM      = wb_out;
  assign addressMW = wb_addr;
  assign writeM    = wb_we;
`else
  assign m_val     = inM;
  assign outM      = alu_out;
  assign addressMW = a_reg;
  assign writeM    = wr_m & rstn;
`endif

endmodule

// File: tb/tb_hack_cpu.sv
// Directed-vector bench for hack_cpu; the bench drives the ROM word and inM directly each cycle.
module tb_hack_cpu;

  logic        clk;
  logic        rstn;
  logic [15:0] inM;
  logic [15:0] instruction;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] addressMR;
  logic [15:0] addressMW;
  logic [15:0] pc;

  int n_cmp;
  int n_bad;
  logic [15:0] pc_exp;

  hack_cpu dut (
    .clk         (clk),
    .rstn        (rstn),
    .inM         (inM),
    .instruction (instruction),
    .outM        (outM),
    .writeM      (writeM),
    .addressMR   (addressMR),
    .addressMW   (addressMW),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Present one instruction and let it execute; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic [15:0] ins, input logic [15:0] m);
    instruction = ins;
    inM = m;
    @(posedge clk);
    #1;
    pc_exp = pc_exp + 16'd1;
  endtask

  // Run a comp-only instruction (no dest, no jump) and check the ALU result on outM.
  task automatic peek(input string tag, input logic [15:0] ins, input logic [15:0] exp);
    cyc(ins, 16'h0000);
    chk(tag, outM, exp);
    chk({tag, "_wm"}, {15'd0, writeM}, 16'd0);
  endtask

  // Execute an M-writing instruction and check the write port where it becomes visible.
  task automatic m_write(input string tag, input logic [15:0] ins, input logic [15:0] m,
                         input logic [15:0] exp_dat, input logic [15:0] exp_adr);
    instruction = ins;
    inM = m;
`ifdef HACK_CPU_WBREG_EN
    #1;
    chk({tag, "_early"}, {15'd0, writeM}, 16'd0);
    cyc(ins, m);
`else
    #1;
`endif
    chk({tag, "_we"},  {15'd0, writeM}, 16'd1);
    chk({tag, "_dat"}, outM, exp_dat);
    chk({tag, "_adr"}, addressMW, exp_adr);
`ifndef HACK_CPU_WBREG_EN
    cyc(ins, m);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pc_exp = 16'h0000;
    rstn = 1'b0;
    inM = 16'h0000;
    instruction = 16'hE7C8;  // M=D+1 held during reset must not strobe
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_wm", {15'd0, writeM}, 16'd0);
    chk("rst_a", addressMR, 16'h0000);

    rstn = 1'b1;
    instruction = 16'h0000;
    #1;
    chk("pc0", pc, 16'h0000);
    pc_exp = 16'h0000;
    cyc(16'h0000, 16'h0000); chk("pc1", pc, 16'h0001);
    cyc(16'h0000, 16'h0000); chk("pc2", pc, 16'h0002);
    cyc(16'h0000, 16'h0000); chk("pc3", pc, 16'h0003);

    // @5 ; D=A
    cyc(16'h0005, 16'h0000); chk("a5", addressMR, 16'h0005);
    cyc(16'hEC10, 16'h0000); chk("pc_da", pc, pc_exp);
    peek("d5", 16'hE300, 16'h0005);

    // @100 ; M=D+1
    cyc(16'd100, 16'h0000);
    m_write("md1", 16'hE7C8, 16'h0000, 16'h0006, 16'd100);
    chk("md1_a", addressMR, 16'd100);
`ifdef HACK_CPU_WBREG_EN
    cyc(16'hFC10, 16'h0000);  // memory not yet updated; forwarding supplies 6
`else
    cyc(16'hFC10, 16'h0006);
`endif
    peek("d_fwd", 16'hE300, 16'h0006);

    // @7 ; D=M ; AM=M+1
    cyc(16'h0007, 16'h0000);
    cyc(16'hFC10, 16'h1234);
    peek("dm", 16'hE300, 16'h1234);
    m_write("amp1", 16'hFDE8, 16'h1234, 16'h1235, 16'h0007);
    chk("amp1_a", addressMR, 16'h1235);

    // ALU AND / OR / SUB paths with D=0x00FF, A=0x0F0F
    cyc(16'h00FF, 16'h0000);
    cyc(16'hEC10, 16'h0000);
    cyc(16'h0F0F, 16'h0000);
    peek("and", 16'hE000, 16'h000F);
    peek("or",  16'hE540, 16'h0FFF);
    peek("sub", 16'hE4C0, 16'hF1F0);

    // Conditional jumps with A=10
    cyc(16'd10, 16'h0000);
    cyc(16'hEA90, 16'h0000);               // D=0
    cyc(16'hE302, 16'h0000); chk("jeq_t", pc, 16'd10);
    pc_exp = 16'd10;
    cyc(16'hEFD0, 16'h0000);               // D=1
    cyc(16'hE302, 16'h0000); chk("jeq_n", pc, 16'd12);
    cyc(16'hEE90, 16'h0000);               // D=-1
    cyc(16'hE304, 16'h0000); chk("jlt_t", pc, 16'd10);
    cyc(16'hE301, 16'h0000); chk("jgt_n", pc, 16'd11);

    // Jump to 0xFFFF, then wrap, then unconditional jump to 3
    cyc(16'hEEA0, 16'h0000);               // A=-1
    chk("a_ff", addressMR, 16'hFFFF);
    cyc(16'hEA87, 16'h0000); chk("jmp_ff", pc, 16'hFFFF);
    cyc(16'h0003, 16'h0000); chk("wrap", pc, 16'h0000);
    cyc(16'hEA87, 16'h0000); chk("jmp3", pc, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
